// File: rtl/local_controller_multitap.sv
// Local-controller ring node: circular sample buffer with a token-driven writer
// and N_TAPS independent read taps (fixed-lag DELAY or one-shot PREFETCH burst).
// Each tap drives its own registered {kind, data, dest} packet lane.
module local_controller_multitap #(
  parameter  int DATAWIDTH = 16,
  parameter  int ADDR_W    = 8,
  parameter  int DEST_W    = 4,
  parameter  int N_TAPS    = 2,
  localparam int TAP_W     = (N_TAPS > 1) ? $clog2(N_TAPS) : 1,
  localparam int PKT_W     = 2 + 2*DATAWIDTH + DEST_W
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [2*DATAWIDTH-1:0]   D,
  input  logic                     write_flag,
  input  logic                     input_write_boundary,
  output logic                     write_boundary_next,
  input  logic                     cfg_valid,
  input  logic [TAP_W-1:0]         cfg_tap,
  input  logic [1:0]               cfg_mode,
  input  logic [ADDR_W-1:0]        cfg_addr_a,
  input  logic [ADDR_W-1:0]        cfg_addr_b,
  input  logic [DEST_W-1:0]        cfg_dest,
  input  logic                     scenario_update,
  output logic [N_TAPS*PKT_W-1:0]  packet_out,
  output logic [N_TAPS-1:0]        out_valid,
  output logic [N_TAPS-1:0]        tap_busy,
  output logic [N_TAPS-1:0]        prefetch_done
);

  localparam int SMP_W = 2*DATAWIDTH;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] K_NONE  = 2'b00;
  localparam logic [1:0] K_DELAY = 2'b01;
  localparam logic [1:0] K_PF    = 2'b10;
  localparam logic [1:0] K_LAST  = 2'b11;

  typedef enum logic {W_IDLE, W_ACTIVE} wr_state_t;
  typedef enum logic [1:0] {T_IDLE, T_DELAY, T_PF} tap_state_t;

  // Writer state
  wr_state_t             wr_state_q, wr_state_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic                  wb_next_q, wb_next_d;
  logic                  wr_en;

  // Sample buffer (never reset; contents are only meaningful once written)
  logic [SMP_W-1:0]      mem [DEPTH];

  // Per-tap configuration and state
  tap_state_t            tap_state_q [N_TAPS];
  tap_state_t            tap_state_d [N_TAPS];
  logic [ADDR_W-1:0]     addr_a_q [N_TAPS];
  logic [ADDR_W-1:0]     addr_a_d [N_TAPS];
  logic [ADDR_W-1:0]     addr_b_q [N_TAPS];
  logic [ADDR_W-1:0]     addr_b_d [N_TAPS];
  logic [DEST_W-1:0]     dest_q   [N_TAPS];
  logic [DEST_W-1:0]     dest_d   [N_TAPS];
  logic [ADDR_W-1:0]     rd_ptr_q [N_TAPS];
  logic [ADDR_W-1:0]     rd_ptr_d [N_TAPS];
  logic [ADDR_W-1:0]     rd_addr  [N_TAPS];
  logic [SMP_W-1:0]      mem_rd   [N_TAPS];

  // Registered packet lanes and status
  logic [1:0]            kind_q  [N_TAPS];
  logic [1:0]            kind_d  [N_TAPS];
  logic [SMP_W-1:0]      data_q  [N_TAPS];
  logic [SMP_W-1:0]      data_d  [N_TAPS];
  logic [DEST_W-1:0]     pdest_q [N_TAPS];
  logic [DEST_W-1:0]     pdest_d [N_TAPS];
  logic [N_TAPS-1:0]     busy_q, busy_d;
  logic [N_TAPS-1:0]     done_q, done_d;

  // Writer: one full pass over the buffer per token, then hand the token on
  always_comb begin
    wr_state_d = wr_state_q;
    wr_ptr_d   = wr_ptr_q;
    wb_next_d  = 1'b0;
    wr_en      = (wr_state_q == W_ACTIVE);
    case (wr_state_q)
      W_IDLE: begin
        if (write_flag || input_write_boundary) wr_state_d = W_ACTIVE;
      end
      W_ACTIVE: begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
          wr_state_d = W_IDLE;
          wb_next_d  = 1'b1;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Writer control registers
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_state_q <= W_IDLE;
      wr_ptr_q   <= '0;
      wb_next_q  <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_ptr_q   <= wr_ptr_d;
      wb_next_q  <= wb_next_d;
    end
  end

  // Buffer write port; reads below see the pre-write contents
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr_q] <= D;
  end

  // Per-tap read address: lagging the writer in DELAY, own pointer otherwise
  always_comb begin
    for (int i = 0; i < N_TAPS; i++) begin
      if (tap_state_q[i] == T_DELAY) rd_addr[i] = wr_ptr_q - addr_a_q[i];
      else                           rd_addr[i] = rd_ptr_q[i];
      mem_rd[i] = mem[rd_addr[i]];
    end
  end

  // Tap sequencing, packet formation and configuration (cfg beats scenario_update)
  always_comb begin
    tap_state_d = tap_state_q;
    rd_ptr_d    = rd_ptr_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    dest_d      = dest_q;
    busy_d      = '0;
    done_d      = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      kind_d[i]  = K_NONE;
      data_d[i]  = '0;
      pdest_d[i] = '0;
      // A completed burst is recognised by its kind-11 packet leaving the lane
      done_d[i]  = (kind_q[i] == K_LAST);
      case (tap_state_q[i])
        T_DELAY: begin
          if (wr_en) begin
            kind_d[i]  = K_DELAY;
            data_d[i]  = (addr_a_q[i] == '0) ? D : mem_rd[i];
            pdest_d[i] = dest_q[i];
          end
        end
        T_PF: begin
          data_d[i]   = mem_rd[i];
          pdest_d[i]  = dest_q[i];
          rd_ptr_d[i] = rd_ptr_q[i] + ADDR_W'(1);
          if (rd_ptr_q[i] == addr_b_q[i]) begin
            kind_d[i]      = K_LAST;
            tap_state_d[i] = T_IDLE;
          end else begin
            kind_d[i] = K_PF;
          end
        end
        default: ;
      endcase
      if (scenario_update) tap_state_d[i] = T_IDLE;
      if (cfg_valid && (int'(cfg_tap) == i)) begin
        case (cfg_mode)
          2'b01:   tap_state_d[i] = T_DELAY;
          2'b10:   tap_state_d[i] = T_PF;
          default: tap_state_d[i] = T_IDLE;
        endcase
        addr_a_d[i] = cfg_addr_a;
        addr_b_d[i] = cfg_addr_b;
        dest_d[i]   = cfg_dest;
        rd_ptr_d[i] = cfg_addr_a;
      end
      // Busy covers the tap's own state plus the packet it is about to present
      busy_d[i] = (tap_state_d[i] != T_IDLE) || (kind_d[i] != K_NONE);
    end
  end

  // Tap control state and output lanes
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_TAPS; i++) begin
        tap_state_q[i] <= T_IDLE;
        kind_q[i]      <= K_NONE;
        data_q[i]      <= '0;
        pdest_q[i]     <= '0;
      end
      busy_q <= '0;
      done_q <= '0;
    end else begin
      for (int i = 0; i < N_TAPS; i++) begin
        tap_state_q[i] <= tap_state_d[i];
        kind_q[i]      <= kind_d[i];
        data_q[i]      <= data_d[i];
        pdest_q[i]     <= pdest_d[i];
      end
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Tap configuration and read pointers (only meaningful while a tap is active)
  always_ff @(posedge CLK) begin
    for (int i = 0; i < N_TAPS; i++) begin
      addr_a_q[i] <= addr_a_d[i];
      addr_b_q[i] <= addr_b_d[i];
      dest_q[i]   <= dest_d[i];
      rd_ptr_q[i] <= rd_ptr_d[i];
    end
  end

  // Pack lanes onto the flat output bus
  always_comb begin
    packet_out = '0;
    out_valid  = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      packet_out[i*PKT_W +: PKT_W] = {kind_q[i], data_q[i], pdest_q[i]};
      out_valid[i]                 = (kind_q[i] != K_NONE);
    end
  end

  assign tap_busy            = busy_q;
  assign prefetch_done       = done_q;
  assign write_boundary_next = wb_next_q;

endmodule

// File: doc/local_controller_multitap.md
# local_controller_multitap

Per-node sample buffer and read engine for the DRBE local-controller ring. It is the parametrised successor of the single-delay / single-prefetch local controller. A circular buffer of DEPTH = 2^ADDR_W samples is filled while the node holds the ring write token. N_TAPS independent read taps each run in DELAY mode (fixed-lag streaming) or PREFETCH mode (one-shot start..stop burst with wrap-around). Each tap emits `{kind, data, dest}` packets toward the NoC on its own registered output lane.

## Interface
- DATAWIDTH, 16, half-sample width; a sample is 2*DATAWIDTH bits (I/Q).
- ADDR_W, 8, buffer address width; DEPTH = 2^ADDR_W.
- DEST_W, 4, destination-address vector width.
- N_TAPS, 2, number of read taps (≥1); TAP_W = max(1, clog2(N_TAPS)).
- PKT_W, derived, 2 + 2*DATAWIDTH + DEST_W.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- D  in  2*DATAWIDTH  input sample stream.
- write_flag  in  1  one-cycle pulse from the global controller; grants the write token.
- input_write_boundary  in  1  one-cycle token pulse from the previous ring node.
- write_boundary_next  out  1  one-cycle token pulse to the next ring node.
- cfg_valid  in  1  tap configuration strobe.
- cfg_tap  in  TAP_W  index of the tap to configure.
- cfg_mode  in  2  00 idle, 01 delay, 10 prefetch, 11 reserved (treated as idle).
- cfg_addr_a  in  ADDR_W  delay value (DELAY mode) or start address (PREFETCH mode).
- cfg_addr_b  in  ADDR_W  stop address (PREFETCH mode only).
- cfg_dest  in  DEST_W  destination address placed in the tap's packets.
- scenario_update  in  1  pulse; idles all taps.
- packet_out  out  N_TAPS*PKT_W  tap i occupies slice i; each slice is {kind[1:0], data[2*DATAWIDTH-1:0], dest[DEST_W-1:0]}.
- out_valid  out  N_TAPS  bit i is high when kind of slice i ≠ 00.
- tap_busy  out  N_TAPS  tap is in DELAY or PREFETCH.
- prefetch_done  out  N_TAPS  one-cycle pulse after a tap's last prefetch packet.

## Operation
- Writer FSM has two states, W_IDLE and W_ACTIVE.
  - W_IDLE → W_ACTIVE on write_flag | input_write_boundary.
  - In W_ACTIVE, each cycle it writes mem[wr_ptr] ← D and increments wr_ptr (mod DEPTH).
  - The cycle that writes address DEPTH-1 is the last active cycle. The next cycle the FSM is in W_IDLE, wr_ptr = 0, and write_boundary_next = 1 for exactly one cycle.
  - Token pulses that arrive while in W_ACTIVE are ignored.
- Memory is a register array and is not reset. Reads of never-written locations are undefined.
- Tap states are T_IDLE, T_DELAY and T_PF. The tap stores mode, addr_a, addr_b, dest and a read pointer rd_ptr.
- DELAY tap: in every W_ACTIVE cycle it reads mem[(wr_ptr - delay) mod DEPTH].
  - delay = 0 bypasses D, i.e. returns the sample being written that cycle.
  - The packet kind is 01. No packet is produced in W_IDLE cycles.
- PREFETCH tap: rd_ptr starts at the start address. Each cycle it emits mem[rd_ptr] with kind 10, then rd_ptr ← rd_ptr + 1 (mod DEPTH).
  - The stop address is emitted with kind 11. The tap then returns to T_IDLE and prefetch_done pulses on the following cycle.
  - Burst length is ((stop - start) mod DEPTH) + 1. start = stop gives a single packet with kind 11.
  - A prefetch runs regardless of writer state. Reading the address being written in the same cycle returns the old contents.
- Configuration: a cfg_valid that targets a busy tap aborts its current activity and restarts it with the new parameters. No prefetch_done is issued for an aborted burst.
  - cfg_tap ≥ N_TAPS is ignored.
- scenario_update forces every tap to T_IDLE. If cfg_valid arrives in the same cycle, the addressed tap takes the new configuration (cfg wins).
- Unused packet fields are driven to 0 when kind = 00.

## Timing
- Reset (asynchronous assert, synchronous-style release) sets:
  - outputs: packet_out = 0, out_valid = 0, tap_busy = 0, prefetch_done = 0, write_boundary_next = 0;
  - state: writer W_IDLE, wr_ptr = 0, all taps T_IDLE.
- Writer: a token pulse in cycle t gives first write in cycle t+1 and last write in t+DEPTH. write_boundary_next is high in cycle t+DEPTH+1.
- Outputs are registered with 1-cycle latency. A read evaluated in cycle c appears on packet_out in c+1.
- Config: cfg_valid in cycle t gives tap_busy = 1 from t+1.
  - For a prefetch, the first packet appears in t+2.
  - For DELAY, the first packet appears one cycle after the first W_ACTIVE cycle at or after t+1.
- PREFETCH: the kind-11 packet is in cycle p. In cycle p+1, prefetch_done = 1, tap_busy = 0 and out_valid = 0.
- scenario_update in cycle t: out_valid is 0 from t+2 (the t+1 output is the last in-flight packet).
- Asserting reset mid-burst or mid-write drops all activity immediately. No boundary pulse and no done pulse are produced.

## Test plan
- Ring write: pulse write_flag with D incrementing from 0x00000000 each cycle → 256 writes; write_boundary_next is high exactly 257 cycles after the pulse; a second token arriving during the write is ignored.
- Delay tap: configure tap0 with delay = 25 (0x19), dest = 4'b1000, then write → after 25 writes, every packet has kind 01, dest 1000 and data = D_written - 25; the tap emits nothing once the writer is idle.
- Prefetch with wrap-around: after a full write of D = 0..255, configure tap1 with start = 0xF0, stop = 0x10, dest = 4'b0110 → 33 packets with data 0xF0..0xFF then 0x00..0x10; the last packet has kind 11; prefetch_done pulses the next cycle.
- Single-entry prefetch: start = stop = 0x30 → one kind-11 packet with data 0x30; tap_busy is high for 1 cycle of output.
- Abort: scenario_update mid-prefetch, together with cfg_valid to tap0 (delay = 0) → tap1 stops with no done pulse; tap0 streams D with zero lag.
- Reset mid-write at write 100 → all outputs are 0 and no boundary pulse occurs; a new token writes from address 0.
